// File: rtl/cell_test_sequencer_if.sv
// Config, status and cell-pin bundle for the
// standard-cell test sequencer.
interface cell_test_sequencer_if #(
  parameter int N_IN     = 2,
  parameter int SETTLE_W = 4,
  parameter int CNT_W    = 16
);
  logic                   start_i;
  logic                   abort_i;
  logic [(1<<N_IN)-1:0]   truth_i;
  logic [SETTLE_W-1:0]    settle_i;
  logic [7:0]             loops_i;
  logic                   cell_y_i;
  logic [N_IN-1:0]        cell_a_o;
  logic                   busy_o;
  logic                   done_o;
  logic                   pass_o;
  logic [CNT_W-1:0]       err_cnt_o;
  logic                   fail_vld_o;
  logic [N_IN-1:0]        fail_vec_o;

  modport master (
    output start_i, abort_i, truth_i,
    output settle_i, loops_i, cell_y_i,
    input  cell_a_o, busy_o, done_o,
    input  pass_o, err_cnt_o,
    input  fail_vld_o, fail_vec_o
  );

  modport slave (
    input  start_i, abort_i, truth_i,
    input  settle_i, loops_i, cell_y_i,
    output cell_a_o, busy_o, done_o,
    output pass_o, err_cnt_o,
    output fail_vld_o, fail_vec_o
  );
endinterface

// File: rtl/cell_test_sequencer.sv
// Sweeps all input vectors of a cell under test,
// compares against a truth table, counts mismatches.
module cell_test_sequencer #(
  parameter int N_IN     = 2,
  parameter int SETTLE_W = 4,
  parameter int CNT_W    = 16
) (
  input logic                  wb_clk_i,
  input logic                  wb_rst_i,
  cell_test_sequencer_if.slave io
);

  localparam int NV = 1 << N_IN;
  localparam logic [N_IN-1:0] VEC_LAST = '1;
  localparam logic [N_IN-1:0] VEC_ONE = N_IN'(1);
  localparam logic [SETTLE_W-1:0] CNT_ONE =
    SETTLE_W'(1);
  localparam logic [CNT_W-1:0] ERR_ONE = CNT_W'(1);
  localparam logic [CNT_W-1:0] ERR_MAX = '1;

  typedef enum logic [1:0] {
    IDLE,
    SETTLE,
    SAMPLE
  } state_t;

  state_t              state_q, state_d;
  logic [N_IN-1:0]     vec_q, vec_d;
  logic [SETTLE_W-1:0] cnt_q, cnt_d;
  logic [SETTLE_W-1:0] settle_q, settle_d;
  logic [7:0]          loops_q, loops_d;
  logic [NV-1:0]       truth_q, truth_d;
  logic                y_q, y_d;
  logic                busy_q, busy_d;
  logic                done_q, done_d;
  logic                pass_q, pass_d;
  logic [CNT_W-1:0]    err_q, err_d;
  logic                fvld_q, fvld_d;
  logic [N_IN-1:0]     fvec_q, fvec_d;
  logic                mis;

  assign mis = y_q != truth_q[vec_q];
  assign y_d = io.cell_y_i;

  always_comb begin
    state_d  = state_q;
    vec_d    = vec_q;
    cnt_d    = cnt_q;
    settle_d = settle_q;
    loops_d  = loops_q;
    truth_d  = truth_q;
    done_d   = 1'b0;
    pass_d   = pass_q;
    err_d    = err_q;
    fvld_d   = fvld_q;
    fvec_d   = fvec_q;
    if (state_q != IDLE && io.abort_i) begin
      // results freeze; pass stays cleared
      state_d = IDLE;
      vec_d   = '0;
    end else begin
      unique case (state_q)
        IDLE: begin
          if (io.start_i && !io.abort_i) begin
            state_d  = SETTLE;
            vec_d    = '0;
            cnt_d    = io.settle_i;
            settle_d = io.settle_i;
            loops_d  = io.loops_i;
            truth_d  = io.truth_i;
            pass_d   = 1'b0;
            err_d    = '0;
            fvld_d   = 1'b0;
            fvec_d   = '0;
          end
        end
        SETTLE: begin
          if (cnt_q == '0) begin
            state_d = SAMPLE;
          end else begin
            cnt_d = cnt_q - CNT_ONE;
          end
        end
        SAMPLE: begin
          if (mis) begin
            if (err_q != ERR_MAX) begin
              err_d = err_q + ERR_ONE;
            end
            if (!fvld_q) begin
              fvld_d = 1'b1;
              fvec_d = vec_q;
            end
          end
          if (vec_q != VEC_LAST) begin
            vec_d   = vec_q + VEC_ONE;
            cnt_d   = settle_q;
            state_d = SETTLE;
          end else if (loops_q == 8'd1) begin
            state_d = IDLE;
            vec_d   = '0;
            done_d  = 1'b1;
            pass_d  = !fvld_q && !mis;
          end else begin
            // loops of zero never counts down
            if (loops_q != 8'd0) begin
              loops_d = loops_q - 8'd1;
            end
            vec_d   = '0;
            cnt_d   = settle_q;
            state_d = SETTLE;
          end
        end
        default: begin
          state_d = IDLE;
          vec_d   = '0;
        end
      endcase
    end
    busy_d = state_d != IDLE;
  end

  always_ff @(posedge wb_clk_i) begin
    if (wb_rst_i) begin
      state_q  <= IDLE;
      vec_q    <= '0;
      cnt_q    <= '0;
      settle_q <= '0;
      loops_q  <= '0;
      truth_q  <= '0;
      y_q      <= 1'b0;
      busy_q   <= 1'b0;
      done_q   <= 1'b0;
      pass_q   <= 1'b0;
      err_q    <= '0;
      fvld_q   <= 1'b0;
      fvec_q   <= '0;
    end else begin
      state_q  <= state_d;
      vec_q    <= vec_d;
      cnt_q    <= cnt_d;
      settle_q <= settle_d;
      loops_q  <= loops_d;
      truth_q  <= truth_d;
      y_q      <= y_d;
      busy_q   <= busy_d;
      done_q   <= done_d;
      pass_q   <= pass_d;
      err_q    <= err_d;
      fvld_q   <= fvld_d;
      fvec_q   <= fvec_d;
    end
  end

  assign io.cell_a_o   = vec_q;
  assign io.busy_o     = busy_q;
  assign io.done_o     = done_q;
  assign io.pass_o     = pass_q;
  assign io.err_cnt_o  = err_q;
  assign io.fail_vld_o = fvld_q;
  assign io.fail_vec_o = fvec_q;

endmodule

// File: tb/tb_cell_test_sequencer.sv
// Bench for cell_test_sequencer: schedule-based model
// plus directed runs with literal expectations.
module tb_cell_test_sequencer;

  localparam int NV = 4;
  localparam int ERR_MAX = 65535;

  logic clk;
  logic rst;
  int   checks;
  int   errors;
  int   cyc;
  int   mode;
  logic [1:0] a_d1, a_d2;

  cell_test_sequencer_if #(
    .N_IN(2), .SETTLE_W(4), .CNT_W(16)
  ) io ();
  cell_test_sequencer_if #(
    .N_IN(2), .SETTLE_W(4), .CNT_W(4)
  ) io2 ();

  cell_test_sequencer #(
    .N_IN(2), .SETTLE_W(4), .CNT_W(16)
  ) dut (
    .wb_clk_i(clk),
    .wb_rst_i(rst),
    .io(io)
  );

  cell_test_sequencer #(
    .N_IN(2), .SETTLE_W(4), .CNT_W(4)
  ) dut_sat (
    .wb_clk_i(clk),
    .wb_rst_i(rst),
    .io(io2)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // cell models: 0 NOR2, 1 stuck-at-1, 2 NOR2 with 2-cycle delay
  assign io.cell_y_i = (mode == 1) ? 1'b1 :
                       (mode == 2) ? ~|a_d2 :
                       ~|io.cell_a_o;
  assign io2.cell_y_i = 1'b1;

  always @(posedge clk) begin
    cyc  <= cyc + 1;
    a_d1 <= io.cell_a_o;
    a_d2 <= a_d1;
  end

  task automatic chk(input string nm,
                     input logic [31:0] act,
                     input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d (cycle %0d)",
               nm, act, exp, cyc);
    end
  endtask

  // Model: position within a run is k cycles since start;
  // each vector spans settle+2 cycles, the last one samples.
  bit         m_run, m_done, m_pass, m_fvld, m_yq;
  int         m_k, m_s, m_l, m_err, m_fvec;
  logic [3:0] m_tr;

  always @(posedge clk) begin : model
    int p, slot, vec, sweep, e;
    bit fv, mis;
    if (rst) begin
      m_run <= 0; m_k <= 0; m_err <= 0; m_fvld <= 0;
      m_fvec <= 0; m_pass <= 0; m_done <= 0; m_yq <= 0;
      m_s <= 0; m_l <= 0; m_tr <= '0;
    end else begin
      m_done <= 0;
      m_yq   <= io.cell_y_i;
      if (!m_run) begin
        if (io.start_i && !io.abort_i) begin
          m_run <= 1; m_k <= 1;
          m_s <= int'(io.settle_i);
          m_l <= int'(io.loops_i);
          m_tr <= io.truth_i;
          m_err <= 0; m_fvld <= 0; m_fvec <= 0;
          m_pass <= 0;
        end
      end else if (io.abort_i) begin
        m_run <= 0;
      end else begin
        p     = m_k - 1;
        slot  = p % (m_s + 2);
        vec   = (p / (m_s + 2)) % NV;
        sweep = p / ((m_s + 2) * NV);
        m_k  <= m_k + 1;
        if (slot == m_s + 1) begin
          mis = m_yq != m_tr[vec];
          e   = m_err;
          fv  = m_fvld;
          if (mis) begin
            if (e < ERR_MAX) e++;
            if (!fv) begin
              fv = 1;
              m_fvec <= vec;
            end
          end
          m_err  <= e;
          m_fvld <= fv;
          if (vec == NV - 1 && m_l != 0 &&
              sweep == m_l - 1) begin
            m_run  <= 0;
            m_done <= 1;
            m_pass <= !fv;
          end
        end
      end
    end
  end

  always @(negedge clk) begin : compare
    int exp_a;
    if (cyc > 0) begin
      exp_a = m_run ? ((m_k - 1) / (m_s + 2)) % NV : 0;
      chk("m_busy", 32'(io.busy_o), 32'(m_run));
      chk("m_cell_a", 32'(io.cell_a_o), exp_a);
      chk("m_done", 32'(io.done_o), 32'(m_done));
      chk("m_pass", 32'(io.pass_o), 32'(m_pass));
      chk("m_err", 32'(io.err_cnt_o), m_err);
      chk("m_fvld", 32'(io.fail_vld_o), 32'(m_fvld));
      chk("m_fvec", 32'(io.fail_vec_o), m_fvec);
    end
  end

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  // returns in cycle 1 of the new run
  task automatic start_run(input logic [3:0] tr,
                           input logic [3:0] st,
                           input logic [7:0] lp);
    io.truth_i  = tr;
    io.settle_i = st;
    io.loops_i  = lp;
    io.start_i  = 1'b1;
    step();
    io.start_i  = 1'b0;
  endtask

  task automatic chk_zero(input string nm);
    chk({nm, "_a"}, 32'(io.cell_a_o), 0);
    chk({nm, "_busy"}, 32'(io.busy_o), 0);
    chk({nm, "_done"}, 32'(io.done_o), 0);
    chk({nm, "_pass"}, 32'(io.pass_o), 0);
    chk({nm, "_err"}, 32'(io.err_cnt_o), 0);
    chk({nm, "_fvld"}, 32'(io.fail_vld_o), 0);
    chk({nm, "_fvec"}, 32'(io.fail_vec_o), 0);
  endtask

  initial begin
    int n;
    int a_exp [8] = '{0, 0, 1, 1, 2, 2, 3, 3};
    checks = 0; errors = 0; cyc = 0; mode = 0;
    a_d1 = '0; a_d2 = '0;
    rst = 1'b1;
    io.start_i = 0; io.abort_i = 0;
    io.truth_i = '0; io.settle_i = '0; io.loops_i = '0;
    io2.start_i = 0; io2.abort_i = 0;
    io2.truth_i = 4'b0001; io2.settle_i = '0;
    io2.loops_i = 8'd0;
    repeat (3) step();
    chk_zero("reset");
    chk("reset_sat_err", 32'(io2.err_cnt_o), 0);
    rst = 1'b0;
    step();

    // NOR2, single sweep
    mode = 0;
    start_run(4'b0001, 4'd0, 8'd1);
    for (int k = 1; k <= 8; k++) begin
      chk("nor_a", 32'(io.cell_a_o), a_exp[k-1]);
      chk("nor_busy", 32'(io.busy_o), 1);
      step();
    end
    chk("nor_done", 32'(io.done_o), 1);
    chk("nor_pass", 32'(io.pass_o), 1);
    chk("nor_busy_end", 32'(io.busy_o), 0);
    chk("nor_err", 32'(io.err_cnt_o), 0);
    chk("nor_fvld", 32'(io.fail_vld_o), 0);

    // stuck-at-1, two sweeps, started in the done cycle
    mode = 1;
    start_run(4'b0001, 4'd0, 8'd2);
    repeat (15) step();
    chk("stk_done16", 32'(io.done_o), 0);
    step();
    chk("stk_done", 32'(io.done_o), 1);
    chk("stk_err", 32'(io.err_cnt_o), 6);
    chk("stk_fvld", 32'(io.fail_vld_o), 1);
    chk("stk_fvec", 32'(io.fail_vec_o), 1);
    chk("stk_pass", 32'(io.pass_o), 0);
    step();

    // delayed NOR2, settle 3
    mode = 2;
    step();
    start_run(4'b0001, 4'd3, 8'd1);
    n = 0;
    while (io.busy_o && n < 200) begin
      n++;
      step();
    end
    chk("dly_busy_len", n, 20);
    chk("dly_done", 32'(io.done_o), 1);
    chk("dly_err", 32'(io.err_cnt_o), 0);
    chk("dly_pass", 32'(io.pass_o), 1);

    // same cell, settle 0: samples stale output
    start_run(4'b0001, 4'd0, 8'd1);
    n = 0;
    while (!io.done_o && n < 200) begin
      n++;
      step();
    end
    chk("dly0_finished", 32'(io.done_o), 1);
    chk("dly0_err_nz", 32'(io.err_cnt_o > 0), 1);
    chk("dly0_pass", 32'(io.pass_o), 0);

    // endless run, abort at cycle 50
    mode = 1;
    step();
    start_run(4'b0001, 4'd0, 8'd0);
    repeat (49) step();
    io.abort_i = 1'b1;
    step();
    io.abort_i = 1'b0;
    chk("abt_busy", 32'(io.busy_o), 0);
    chk("abt_a", 32'(io.cell_a_o), 0);
    chk("abt_err", 32'(io.err_cnt_o), 18);
    for (int k = 0; k < 10; k++) begin
      chk("abt_nodone", 32'(io.done_o), 0);
      chk("abt_hold", 32'(io.err_cnt_o), 18);
      step();
    end
    chk("abt_pass", 32'(io.pass_o), 0);

    // 4-bit counter saturation
    io2.start_i = 1'b1;
    step();
    io2.start_i = 1'b0;
    repeat (8) step();
    chk("sat_err9", 32'(io2.err_cnt_o), 3);
    repeat (191) step();
    for (int k = 0; k < 10; k++) begin
      chk("sat_err", 32'(io2.err_cnt_o), 15);
      chk("sat_busy", 32'(io2.busy_o), 1);
      step();
    end
    io2.abort_i = 1'b1;
    step();
    io2.abort_i = 1'b0;
    chk("sat_abort_busy", 32'(io2.busy_o), 0);
    chk("sat_abort_err", 32'(io2.err_cnt_o), 15);

    // start pulse mid-run is ignored
    mode = 0;
    start_run(4'b0001, 4'd0, 8'd1);
    step();
    step();
    io.start_i = 1'b1;
    step();
    io.start_i = 1'b0;
    repeat (4) step();
    chk("ign_done8", 32'(io.done_o), 0);
    chk("ign_busy8", 32'(io.busy_o), 1);
    step();
    chk("ign_done9", 32'(io.done_o), 1);
    chk("ign_pass9", 32'(io.pass_o), 1);
    step();
    chk("ign_idle", 32'(io.busy_o), 0);

    // reset mid-run
    mode = 1;
    start_run(4'b0001, 4'd0, 8'd0);
    repeat (4) step();
    rst = 1'b1;
    step();
    rst = 1'b0;
    chk_zero("midrst");

    // fresh start after reset
    mode = 0;
    step();
    start_run(4'b0001, 4'd0, 8'd1);
    repeat (8) step();
    chk("fresh_done", 32'(io.done_o), 1);
    chk("fresh_pass", 32'(io.pass_o), 1);
    chk("fresh_err", 32'(io.err_cnt_o), 0);
    step();
    step();

    $display("Simulation finished: %0d checks, %0d errors",
             checks, errors);
    $finish;
  end

endmodule

// File: doc/cell_test_sequencer.md
# cell_test_sequencer

Self-checking stimulus controller for a single combinational standard cell under test on the testwafer user area. It drives every input combination of an N-input cell in sequence and waits a programmable settle time per vector. It then samples the cell output and compares it against a programmed truth table, accumulating a mismatch count and the first failing vector. It sits between the Caravel user-project wrapper (config from logic-analyzer or IO pins, clock from `wb_clk_i`) and the cell instance it exercises.

## Interface
Parameters:
- `N_IN`, 2, number of cell inputs (1..4); vector space is 2**N_IN.
- `SETTLE_W`, 4, width of settle-count field.
- `CNT_W`, 16, width of mismatch counter.

Ports:
- `wb_clk_i`  in  1  sole clock.
- `wb_rst_i`  in  1  reset, synchronous, active-high.
- `start_i`  in  1  start request; honoured only in IDLE.
- `abort_i`  in  1  stop run; wins over everything except reset.
- `truth_i`  in  2**N_IN  expected output, bit v = expected Y for input vector v; latched at start.
- `settle_i`  in  SETTLE_W  extra wait cycles per vector; latched at start.
- `loops_i`  in  8  number of full sweeps; 0 = run until abort; latched at start.
- `cell_y_i`  in  1  output of cell under test.
- `cell_a_o`  out  N_IN  registered input vector driven to cell (bit 0 = A, bit 1 = A1, ...).
- `busy_o`  out  1  run in progress.
- `done_o`  out  1  one-cycle pulse on normal completion.
- `pass_o`  out  1  last completed run had zero mismatches.
- `err_cnt_o`  out  CNT_W  mismatch count, saturating at all-ones.
- `fail_vld_o`  out  1  at least one mismatch this run.
- `fail_vec_o`  out  N_IN  first mismatching vector.

## Operation
- States: IDLE, SETTLE, SAMPLE.
- `y_q`: `cell_y_i` registered every cycle.
- IDLE + `start_i`:
  - latch config; vec=0, `cell_a_o`<=0, cnt<=`settle_i`;
  - loop counter <= `loops_i`;
  - clear `err_cnt_o`, `fail_vld_o`, `fail_vec_o`, `pass_o`;
  - go to SETTLE.
- SETTLE: if cnt==0 go to SAMPLE, else cnt--.
- SAMPLE:
  - If `y_q`!=truth[vec]: increment `err_cnt_o` (saturating). If `fail_vld_o`==0, set it and latch `fail_vec_o`=vec.
  - If vec < 2**N_IN-1: vec++, `cell_a_o`<=vec+1, cnt<=settle, go to SETTLE.
  - Else (end of sweep):
    - If loops==1: go to IDLE, pulse `done_o`, set `pass_o` = no mismatch in entire run, including this sample.
    - Otherwise: decrement loops if non-zero, vec=0, `cell_a_o`<=0, go to SETTLE. Loops==0 means run forever.
- `abort_i` in SETTLE/SAMPLE: next state IDLE, `cell_a_o`<=0. No `done_o`, `pass_o` stays 0, counters hold their values. `abort_i` in IDLE has no effect.
- `abort_i` and `start_i` in the same IDLE cycle: start is ignored.
- `start_i` outside IDLE is ignored; no queuing.
- `busy_o` = state!=IDLE, registered with state.

## Timing
- Reset: state IDLE. All outputs 0: `cell_a_o`, `busy_o`, `done_o`, `pass_o`, `err_cnt_o`, `fail_vld_o`, `fail_vec_o`. `y_q`=0.
- Reset mid-run behaves exactly as reset from idle; no result is kept.
- `start_i` sampled at cycle 0 → cycle 1: `busy_o`=1, `cell_a_o`=0.
- Each vector occupies settle+2 cycles: settle+1 in SETTLE, 1 in SAMPLE.
- The compared `y_q` reflects `cell_y_i` at least settle+1 cycles after `cell_a_o` changed.
- Single sweep: `busy_o` high for 2**N_IN×(settle+2) cycles. The next cycle has `done_o`=1 and `busy_o`=0, with final `err_cnt_o`/`pass_o` already valid.
- Result outputs update the cycle after the SAMPLE cycle that causes them.
- Back-to-back: `start_i` may be asserted in the `done_o` cycle; it is accepted.

## Test plan
- NOR2 model, N_IN=2, truth=4'b0001, settle=0, loops=1, start at cycle 0:
  - `cell_a_o` = 0,0,1,1,2,2,3,3 over cycles 1-8;
  - `done_o` and `pass_o`=1 at cycle 9;
  - `err_cnt_o`=0, `fail_vld_o`=0.
- Cell output stuck at 1, truth=4'b0001, loops=2 → `err_cnt_o`=6, `fail_vld_o`=1, `fail_vec_o`=1, `pass_o`=0, `done_o` at cycle 17.
- settle=3, loops=1, NOR2 model with 2-cycle output delay → `busy_o` high exactly 20 cycles, zero mismatches. With settle=0 the same model → `err_cnt_o`>0.
- loops=0, stuck-at-1 cell, abort at cycle 50:
  - cycle 51: IDLE, `cell_a_o`=0;
  - `done_o` never pulses, `err_cnt_o` holds its value.
- CNT_W=4, loops=0, stuck-at-1 cell for 200 cycles → `err_cnt_o` saturates at 15 and stays there.
- `start_i` pulsed at cycle 3 of a run → ignored, sweep timing unchanged.
- `wb_rst_i` at cycle 5 → all outputs 0 next cycle.
- Fresh start afterwards → clean pass.
